// File: rtl/core_pipe_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package core_pipe_fetch_pkg;

    localparam int XL        = 63;  // MSB of a 64-bit address / data word
    localparam int FD_IBUF_R = 31;  // MSB of the instruction presented to decode
    localparam int FD_ERR_R  = 1;   // MSB of the per-halfword fetch error vector
    localparam int BUF_HW    = 8;   // parcel buffer depth in halfwords

    localparam logic [XL:0] FETCH_PC_RESET_DEFAULT = 64'h8000_0000;

    // Memory request sequencing: idle, request presented, response outstanding.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/core_fetch_buffer.sv
// Halfword parcel buffer: shifts out consumed halfwords and appends the
// useful halfwords of a fetched doubleword behind whatever remains.
module core_fetch_buffer
    import core_pipe_fetch_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic [1:0]  eat_hw,
    input  logic        app_valid,
    input  logic [63:0] app_data,
    input  logic [1:0]  app_skip,
    input  logic        app_err,
    output logic [3:0]  count,
    output logic [3:0]  count_next,
    output logic [31:0] head_data,
    output logic [1:0]  head_err
);

    logic [15:0]       data_q [BUF_HW];
    logic [15:0]       data_d [BUF_HW];
    logic [BUF_HW-1:0] err_q;
    logic [BUF_HW-1:0] err_d;
    logic [3:0]        count_q;
    logic [3:0]        count_d;
    logic [3:0]        base;
    logic [3:0]        pos;
    logic [2:0]        src;

    // Shift out eaten halfwords, then drop the appended halfwords in behind the survivors.
    always_comb begin
        // NOTE: every variable gets a value before any conditional logic so no latch is inferred.
        data_d = data_q;
        err_d  = err_q;
        src    = '0;
        pos    = '0;
        base   = count_q - {2'b00, eat_hw};
        for (int i = 0; i < BUF_HW; i++) begin
            if (i + int'(eat_hw) < BUF_HW) begin
                src       = 3'(i) + {1'b0, eat_hw};
                data_d[i] = data_q[src];
                err_d[i]  = err_q[src];
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (app_valid && (2'(j) >= app_skip)) begin
                pos = base + 4'(j) - {2'b00, app_skip};
                if (pos < 4'(BUF_HW)) begin
                    data_d[pos[2:0]] = app_data[16*j +: 16];
                    err_d[pos[2:0]]  = app_err;
                end
            end
        end
        count_d = app_valid ? (base + 4'd4 - {2'b00, app_skip}) : base;
        if (flush) begin
            count_d = '0;
        end
    end

    // Occupancy register; it alone decides which halfwords are meaningful.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
        if (!g_resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Halfword storage and error flags.
    // NOTE: storage is deliberately not reset; count_q gates every read of it.
    always_ff @(posedge g_clk) begin
        data_q <= data_d;
        err_q  <= err_d;
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign head_data  = {data_q[1], data_q[0]};
    assign head_err   = err_q[1:0];

endmodule

// File: rtl/core_pipe_fetch.sv
// Instruction fetch stage: sequences aligned 64-bit memory reads, feeds the
// parcel buffer and presents the head RV64C/RV64I instruction to decode.
module core_pipe_fetch
    import core_pipe_fetch_pkg::*;
#(
    parameter logic [XL:0] FETCH_PC_RESET = FETCH_PC_RESET_DEFAULT
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               cf_req,
    input  logic [XL:0]        cf_target,
    output logic               cf_ack,
    output logic               imem_req,
    input  logic               imem_gnt,
    output logic [XL:0]        imem_addr,
    input  logic               imem_recv,
    output logic               imem_ack,
    input  logic               imem_error,
    input  logic [XL:0]        imem_rdata,
    output logic               s1_16bit,
    output logic               s1_32bit,
    output logic [FD_IBUF_R:0] s1_instr,
    output logic [XL:0]        s1_pc,
    output logic [XL:0]        s1_npc,
    output logic [FD_ERR_R:0]  s1_ferr,
    input  logic               s2_eat_2,
    input  logic               s2_eat_4
);

    localparam logic [XL:0] RESET_PC = {FETCH_PC_RESET[XL:1], 1'b0};

    fetch_state_e state_q, state_d;
    logic [XL:0]  fetch_addr_q, fetch_addr_d;
    logic [XL:0]  s1_pc_q, s1_pc_d;
    logic [1:0]   skip_q, skip_d;
    logic         drop_q, drop_d;
    logic         halt_q, halt_d;

    logic         req_fire;
    logic         resp;
    logic [1:0]   eat_hw;
    logic         app_valid;
    logic [3:0]   buf_count;
    logic [3:0]   buf_count_next;
    logic [31:0]  head_data;
    logic [1:0]   head_err;

    assign imem_req  = (state_q == FS_REQ);
    assign imem_addr = fetch_addr_q;
    assign imem_ack  = 1'b1;
    // A presented but ungranted request must keep its address, so redirects wait.
    assign cf_ack    = cf_req && !(imem_req && !imem_gnt);
    assign req_fire  = imem_req && imem_gnt;
    assign resp      = (state_q == FS_WAIT) && imem_recv;
    assign app_valid = resp && !drop_q;
    assign eat_hw    = s2_eat_4 ? 2'd2 : (s2_eat_2 ? 2'd1 : 2'd0);

    core_fetch_buffer u_buf (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (cf_ack),
        .eat_hw     (eat_hw),
        .app_valid  (app_valid),
        .app_data   (imem_rdata),
        .app_skip   (skip_q),
        .app_err    (imem_error),
        .count      (buf_count),
        .count_next (buf_count_next),
        .head_data  (head_data),
        .head_err   (head_err)
    );

    // Request sequencing, PC tracking and redirect handling; a redirect overrides everything else.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        s1_pc_d      = s1_pc_q;
        skip_d       = skip_q;
        drop_d       = drop_q;
        halt_d       = halt_q;

        if (s2_eat_4) begin
            s1_pc_d = s1_pc_q + 64'd4;
        end else if (s2_eat_2) begin
            s1_pc_d = s1_pc_q + 64'd2;
        end
        if (req_fire) begin
            fetch_addr_d = fetch_addr_q + 64'd8;
        end
        if (resp) begin
            drop_d = 1'b0;
        end
        if (app_valid) begin
            skip_d = 2'd0;
            if (imem_error) begin
                halt_d = 1'b1;
            end
        end

        case (state_q)
            FS_IDLE: if (!halt_q && buf_count <= 4'd4) state_d = FS_REQ;
            FS_REQ:  if (imem_gnt) state_d = FS_WAIT;
            FS_WAIT: if (resp) state_d = (!halt_d && buf_count_next <= 4'd4) ? FS_REQ : FS_IDLE;
            default: state_d = FS_IDLE;
        endcase

        if (cf_ack) begin
            s1_pc_d      = {cf_target[XL:1], 1'b0};
            fetch_addr_d = {cf_target[XL:3], 3'b000};
            skip_d       = cf_target[2:1];
            halt_d       = 1'b0;
            drop_d       = req_fire || ((state_q == FS_WAIT) && !imem_recv);
            state_d      = drop_d ? FS_WAIT : FS_REQ;
        end
    end

    // Fetch control registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q      <= FS_IDLE;
            fetch_addr_q <= {RESET_PC[XL:3], 3'b000};
            s1_pc_q      <= RESET_PC;
            skip_q       <= RESET_PC[2:1];
            drop_q       <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            s1_pc_q      <= s1_pc_d;
            skip_q       <= skip_d;
            drop_q       <= drop_d;
            halt_q       <= halt_d;
        end
    end

    assign s1_16bit = (buf_count >= 4'd1) && (head_data[1:0] != 2'b11);
    assign s1_32bit = (buf_count >= 4'd2) && (head_data[1:0] == 2'b11);
    assign s1_instr = s1_16bit ? {16'h0000, head_data[15:0]} : head_data;
    assign s1_ferr  = s1_16bit ? {1'b0, head_err[0]} : head_err;
    assign s1_pc    = s1_pc_q;
    assign s1_npc   = s1_pc_q + (s1_16bit ? 64'd2 : 64'd4);

    a_eat_exclusive: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(s2_eat_2 && s2_eat_4));
    a_eat2_valid: assert property (@(posedge g_clk) disable iff (!g_resetn)
        s2_eat_2 |-> s1_16bit);
    a_eat4_valid: assert property (@(posedge g_clk) disable iff (!g_resetn)
        s2_eat_4 |-> s1_32bit);

endmodule
